// File: rtl/result_writeback_pkg.sv
// Shared types and default sizes for the result write-back unit.
// Each pending FIFO slot holds one {addr, data} entry.
package result_writeback_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 3;
  localparam int WB_DEPTH  = 2;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic is_r0(
    input logic [WB_ADDR_W-1:0] a
  );
    return a == '0;
  endfunction

endpackage

// File: rtl/result_writeback_if.sv
// ALU result handshake: producer (master) offers {addr, data},
// the write-back unit (slave) accepts when ready.
interface result_writeback_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [ADDR_W-1:0] res_addr;

  modport master (
    output res_valid,
    output res_data,
    output res_addr,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_addr,
    output res_ready
  );

endinterface

// File: rtl/result_writeback_wb_fifo.sv
// Ring buffer of pending results; exposes entries oldest-first
// with valid bits so the owner can forward from them.
module wb_fifo
  import result_writeback_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  wb_entry_t              entry_i,
  input  logic                   pop_i,
  output wb_entry_t              ents_o [DEPTH],
  output logic [DEPTH-1:0]       vld_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] head_d;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W-1:0] tail_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) begin
      mem_d[tail_q] = entry_i;
      tail_d        = tail_q + PTR_W'(1);
    end
    if (pop_i) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Slot k is the k-th oldest pending entry.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ents_o[k] = mem_q[head_q + PTR_W'(k)];
      vld_o[k]  = CNT_W'(k) < count_q;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/result_writeback.sv
// Write-back unit: buffers ALU results, drains one per cycle into
// an r0-hardwired register file, and forwards pending values to reads.
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  result_writeback_if.slave      res,
  input  logic                   wb_hold,
  input  logic [ADDR_W-1:0]      rd_addr_a,
  output logic [DATA_W-1:0]      rd_data_a,
  input  logic [ADDR_W-1:0]      rd_addr_b,
  output logic [DATA_W-1:0]      rd_data_b,
  output logic [$clog2(DEPTH):0] wb_count,
  output logic                   wb_busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NREG  = 2 ** ADDR_W;

  wb_entry_t         ents [DEPTH];
  wb_entry_t         push_ent;
  logic [DEPTH-1:0]  vld;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];

  assign res.res_ready = (count < CNT_W'(DEPTH)) && rst_n;
  assign push          = res.res_valid && res.res_ready;
  assign pop           = (count != '0) && !wb_hold;
  assign push_ent.addr = res.res_addr;
  assign push_ent.data = res.res_data;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .entry_i (push_ent),
    .pop_i   (pop),
    .ents_o  (ents),
    .vld_o   (vld),
    .count_o (count)
  );

  always_comb begin
    rf_d = rf_q;
    if (pop && !is_r0(ents[0].addr)) begin
      rf_d[ents[0].addr] = ents[0].data;
    end
    rf_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    rd_data_a = rf_q[rd_addr_a];
    rd_data_b = rf_q[rd_addr_b];
    for (int k = 0; k < DEPTH; k++) begin
      if (vld[k] && !is_r0(ents[k].addr)) begin
        if (ents[k].addr == rd_addr_a) begin
          rd_data_a = ents[k].data;
        end
        if (ents[k].addr == rd_addr_b) begin
          rd_data_b = ents[k].data;
        end
      end
    end
    if (is_r0(rd_addr_a)) begin
      rd_data_a = '0;
    end
    if (is_r0(rd_addr_b)) begin
      rd_data_b = '0;
    end
  end

  assign wb_count = count;
  assign wb_busy  = count != '0;

endmodule

// File: tb/tb_result_writeback.sv
// Bench for result_writeback: directed table, reset cases and
// randomized traffic against a queue-based reference model.
module tb_result_writeback;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DP = 2;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          wb_hold = 0;
  logic [AW-1:0] rd_addr_a = 0;
  logic [AW-1:0] rd_addr_b = 0;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic [$clog2(DP):0] wb_count;
  logic          wb_busy;

  int checks = 0;
  int failures = 0;

  result_writeback_if #(.DATA_W(DW), .ADDR_W(AW)) rif ();

  result_writeback #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res       (rif.slave),
    .wb_hold   (wb_hold),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .wb_count  (wb_count),
    .wb_busy   (wb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ment_t;

  ment_t         mq[$];
  logic [DW-1:0] mrf [8];

  typedef struct {
    bit            v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            h;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    bit            er;
    int            ec;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] ad);
    if (ad == 0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a == ad) return mq[i].d;
    end
    return mrf[ad];
  endfunction

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < 8; i++) mrf[i] = '0;
  endtask

  task automatic apply(input bit v, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit h,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    rif.res_valid = v;
    rif.res_addr  = a;
    rif.res_data  = d;
    wb_hold       = h;
    rd_addr_a     = ra;
    rd_addr_b     = rb;
    @(negedge clk);
  endtask

  // Advance one edge and update the model from pre-edge state.
  task automatic commit();
    bit    do_pop;
    bit    do_push;
    ment_t e;
    do_pop  = (mq.size() > 0) && !wb_hold && rst_n;
    do_push = rif.res_valid && (mq.size() < DP) && rst_n;
    e.a = rif.res_addr;
    e.d = rif.res_data;
    @(posedge clk);
    if (do_pop) begin
      ment_t h;
      h = mq.pop_front();
      if (h.a != 0) mrf[h.a] = h.d;
    end
    if (do_push) mq.push_back(e);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ready"}, 32'(rif.res_ready), 32'(mq.size() < DP));
    chk({tag, "_count"}, 32'(wb_count), 32'(mq.size()));
    chk({tag, "_busy"}, 32'(wb_busy), 32'(mq.size() != 0));
    chk({tag, "_rd_a"}, 32'(rd_data_a), 32'(model_rd(rd_addr_a)));
    chk({tag, "_rd_b"}, 32'(rd_data_b), 32'(model_rd(rd_addr_b)));
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 1; r < 8; r++) begin
      rd_addr_a = AW'(r);
      rd_addr_b = AW'(8 - r);
      #1;
      chk({tag, "_zero_a"}, 32'(rd_data_a), 32'h0);
      chk({tag, "_zero_b"}, 32'(rd_data_b), 32'h0);
    end
  endtask

  initial begin
    rif.res_valid = 0;
    rif.res_addr  = 0;
    rif.res_data  = 0;
    model_clear();

    vt[0]  = '{1, 3, 16'hBEEF, 0, 3, 3, 1, 0, 16'h0000, 16'h0000};
    vt[1]  = '{0, 0, 16'h0000, 0, 3, 0, 1, 1, 16'hBEEF, 16'h0000};
    vt[2]  = '{0, 0, 16'h0000, 0, 3, 3, 1, 0, 16'hBEEF, 16'hBEEF};
    vt[3]  = '{1, 5, 16'h1111, 1, 5, 5, 1, 0, 16'h0000, 16'h0000};
    vt[4]  = '{1, 5, 16'h2222, 1, 5, 5, 1, 1, 16'h1111, 16'h1111};
    vt[5]  = '{1, 2, 16'h00AA, 1, 5, 5, 0, 2, 16'h2222, 16'h2222};
    vt[6]  = '{1, 2, 16'h00AA, 0, 5, 2, 0, 2, 16'h2222, 16'h0000};
    vt[7]  = '{1, 2, 16'h00AA, 0, 5, 2, 1, 1, 16'h2222, 16'h0000};
    vt[8]  = '{0, 0, 16'h0000, 0, 2, 5, 1, 1, 16'h00AA, 16'h2222};
    vt[9]  = '{1, 0, 16'hFFFF, 0, 0, 2, 1, 0, 16'h0000, 16'h00AA};
    vt[10] = '{0, 0, 16'h0000, 0, 0, 2, 1, 1, 16'h0000, 16'h00AA};
    vt[11] = '{0, 0, 16'h0000, 0, 0, 3, 1, 0, 16'h0000, 16'hBEEF};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rif.res_ready), 32'h0);
    chk("rst_count", 32'(wb_count), 32'h0);
    chk("rst_busy", 32'(wb_busy), 32'h0);
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rel_ready", 32'(rif.res_ready), 32'h1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      apply(vt[i].v, vt[i].a, vt[i].d, vt[i].h, vt[i].ra, vt[i].rb);
      chk({t, "_ready"}, 32'(rif.res_ready), 32'(vt[i].er));
      chk({t, "_count"}, 32'(wb_count), 32'(vt[i].ec));
      chk({t, "_busy"}, 32'(wb_busy), 32'(vt[i].ec != 0));
      chk({t, "_rd_a"}, 32'(rd_data_a), 32'(vt[i].ea));
      chk({t, "_rd_b"}, 32'(rd_data_b), 32'(vt[i].eb));
      commit();
    end

    apply(1, 1, 16'h1234, 1, 1, 6);
    commit();
    apply(1, 6, 16'h5678, 1, 1, 6);
    commit();
    apply(0, 0, 16'h0000, 1, 1, 6);
    chk("mid_count", 32'(wb_count), 32'h2);
    chk("mid_fwd_a", 32'(rd_data_a), 32'h1234);
    chk("mid_fwd_b", 32'(rd_data_b), 32'h5678);
    #1;
    rst_n = 0;
    #1;
    model_clear();
    chk("mid_rst_count", 32'(wb_count), 32'h0);
    chk("mid_rst_ready", 32'(rif.res_ready), 32'h0);
    chk("mid_rst_busy", 32'(wb_busy), 32'h0);
    check_all_zero("mid_rst");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 16'h0000, 0, 1, 6);
      check_model("post_rst");
      chk("post_rst_r1", 32'(rd_data_a), 32'h0);
      chk("post_rst_r6", 32'(rd_data_b), 32'h0);
      commit();
    end

    for (int i = 0; i < 400; i++) begin
      apply(bit'($urandom_range(0, 3) != 0),
            AW'($urandom_range(0, 7)),
            DW'($urandom),
            bit'($urandom_range(0, 9) < 3),
            AW'($urandom_range(0, 7)),
            AW'($urandom_range(0, 7)));
      check_model("rnd");
      commit();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
